// File: rtl/vpu_mask_pkg.sv
// -----------------------------------------------------------------------------
// vpu_mask_pkg
// Shared definitions for the vector mask sequencer and its lane expander:
//   - SEW encodings (element width selector)
//   - sequencer FSM state encoding
//   - helpers for VLMAX (elements per register) and log2 of elements per beat
// -----------------------------------------------------------------------------
package vpu_mask_pkg;

  typedef enum logic [1:0] {
    SEW_8   = 2'b00,
    SEW_16  = 2'b01,
    SEW_32  = 2'b10,
    SEW_RSV = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // The reserved encoding behaves as 32-bit elements, so after this every
  // SEW code doubles as log2(element bytes).
  function automatic logic [1:0] sew_norm(input logic [1:0] sew);
    return (sew == SEW_RSV) ? SEW_32 : sew;
  endfunction

  // Elements held by a VLEN-bit register at the given (normalised) SEW.
  function automatic int unsigned vlmax_f(input int unsigned vlen, input logic [1:0] sew);
    return vlen >> (3 + int'(sew));
  endfunction

  // log2 of elements per beat: log2(BEAT_BYTES) - log2(element bytes).
  function automatic int unsigned epb_log_f(input int unsigned beat_log, input logic [1:0] sew);
    return beat_log - int'(sew);
  endfunction

endpackage

// File: rtl/vector_mask_lane_expand.sv
// -----------------------------------------------------------------------------
// vector_mask_lane_expand
// Combinational expansion of the element mask into per-byte write enables for
// one output beat.
// Ports:
//   mask         element mask, bit n = element n
//   vl           active element count (already clamped to VLMAX)
//   sew          normalised element width code (0=8, 1=16, 2=32)
//   mask_skip    treat every mask bit as 1
//   first_fault  prefix-AND enables across the beat
//   beat         beat number being expanded
//   update_bits  per-byte enables for this beat
//   beat_fault   this beat holds an in-vl element that is disabled (ff only)
// -----------------------------------------------------------------------------
module vector_mask_lane_expand
  import vpu_mask_pkg::*;
#(
  parameter int VLEN       = 256,
  parameter int BEAT_BYTES = 4,
  localparam int VL_W      = $clog2(VLEN) + 1,
  localparam int NBEATS    = VLEN / (8 * BEAT_BYTES),
  localparam int BI_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic [VLEN-1:0]       mask,
  input  logic [VL_W-1:0]       vl,
  input  logic [1:0]            sew,
  input  logic                  mask_skip,
  input  logic                  first_fault,
  input  logic [BI_W-1:0]       beat,
  output logic [BEAT_BYTES-1:0] update_bits,
  output logic                  beat_fault
);

  localparam int BB_LOG = $clog2(BEAT_BYTES);
  localparam int IDX_W  = $clog2(VLEN);

  logic [VL_W-1:0]       epb;
  logic [VL_W-1:0]       base;
  logic [VL_W-1:0]       elem;
  logic                  in_vl;
  logic                  en;
  logic                  run_ok;
  logic [BEAT_BYTES-1:0] elem_en;
  logic [BB_LOG-1:0]     lane_elem;

  // A beat only ever starts once every earlier beat was fully enabled (a
  // first-fault beat ends the command), so the prefix-AND only has to run
  // across the elements of the current beat.
  always_comb begin
    epb         = VL_W'(BEAT_BYTES) >> sew;
    base        = VL_W'(beat) << (BB_LOG - int'(sew));
    elem        = '0;
    in_vl       = 1'b0;
    en          = 1'b0;
    run_ok      = 1'b1;
    beat_fault  = 1'b0;
    elem_en     = '0;
    update_bits = '0;
    lane_elem   = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      elem  = base + VL_W'(k);
      in_vl = (VL_W'(k) < epb) && (elem < vl);
      en    = in_vl && (mask_skip || mask[elem[IDX_W-1:0]]);
      if (first_fault) begin
        if (in_vl && !en) beat_fault = 1'b1;
        // Tail elements do not break the chain.
        run_ok = run_ok && (en || !in_vl);
        en     = en && run_ok;
      end
      elem_en[k] = en;
    end
    for (int j = 0; j < BEAT_BYTES; j++) begin
      lane_elem      = BB_LOG'(j) >> sew;
      update_bits[j] = elem_en[lane_elem];
    end
  end

endmodule

// File: rtl/vector_mask_sequencer.sv
// -----------------------------------------------------------------------------
// vector_mask_sequencer
// Latches a vector mask command and streams it out as beats of per-byte write
// enables, one beat per cycle under continuous ready.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start                      command request (taken only when idle)
//   i_mask, i_vl, i_sew          element mask, active length, element width
//   i_mask_skip, i_first_fault   unmasked op, fault-only-first mode
//   o_busy                       command in progress (RUN or DONE)
//   o_valid / i_ready            beat handshake
//   o_update_bits                per-byte enables of the current beat
//   o_beat_idx, o_last           beat number, final-beat flag
//   o_fault                      first-fault termination, sticky to next start
//   o_alu2_8, o_alu2_16          latched SEW decode while busy
//   o_done                       one-cycle completion pulse
// -----------------------------------------------------------------------------
module vector_mask_sequencer
  import vpu_mask_pkg::*;
#(
  parameter int VLEN       = 256,
  parameter int BEAT_BYTES = 4,
  localparam int VL_W      = $clog2(VLEN) + 1,
  localparam int NBEATS    = VLEN / (8 * BEAT_BYTES),
  localparam int BI_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [VLEN-1:0]       i_mask,
  input  logic [VL_W-1:0]       i_vl,
  input  logic [1:0]            i_sew,
  input  logic                  i_mask_skip,
  input  logic                  i_first_fault,
  output logic                  o_busy,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BEAT_BYTES-1:0] o_update_bits,
  output logic [BI_W-1:0]       o_beat_idx,
  output logic                  o_last,
  output logic                  o_fault,
  output logic                  o_alu2_8,
  output logic                  o_alu2_16,
  output logic                  o_done
);

  localparam int BB_LOG = $clog2(BEAT_BYTES);

  state_e                state_q, state_d;
  logic [VLEN-1:0]       mask_lat;
  logic [VL_W-1:0]       vl_lat;
  logic [1:0]            sew_lat;
  logic                  skip_lat;
  logic                  ff_lat;
  logic [BI_W-1:0]       beat_q;
  logic                  fault_q;

  logic                  accept;
  logic                  handshake;
  logic                  is_last;
  logic                  beat_fault;
  logic [BEAT_BYTES-1:0] lane_bits;
  logic [VL_W-1:0]       epb;
  logic [VL_W-1:0]       epb_log;
  logic [VL_W-1:0]       beats_total;

  // Saturate the requested length to what the register holds at this SEW.
  function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl,
                                               input logic [1:0] sew);
    logic [VL_W-1:0] vmax;
    vmax = VL_W'(vlmax_f(VLEN, sew));
    return (vl > vmax) ? vmax : vl;
  endfunction

  assign accept    = (state_q == ST_IDLE) && i_start;
  assign handshake = o_valid && i_ready;

  assign epb         = VL_W'(BEAT_BYTES) >> sew_lat;
  assign epb_log     = VL_W'(epb_log_f(BB_LOG, sew_lat));
  assign beats_total = (vl_lat + epb - VL_W'(1)) >> epb_log;
  assign is_last     = (VL_W'(beat_q) == beats_total - VL_W'(1)) || beat_fault;

  vector_mask_lane_expand #(
    .VLEN       (VLEN),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_lane_expand (
    .mask        (mask_lat),
    .vl          (vl_lat),
    .sew         (sew_lat),
    .mask_skip   (skip_lat),
    .first_fault (ff_lat),
    .beat        (beat_q),
    .update_bits (lane_bits),
    .beat_fault  (beat_fault)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_start) state_d = (i_vl == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (handshake && is_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        beat_q  <= '0;
        fault_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        if (handshake && !is_last) beat_q <= beat_q + BI_W'(1);
        if (beat_fault) fault_q <= 1'b1;
      end
    end
  end

  // Command capture: data only, qualified by state so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mask_lat <= i_mask;
      sew_lat  <= sew_norm(i_sew);
      vl_lat   <= clamp_vl(i_vl, sew_norm(i_sew));
      skip_lat <= i_mask_skip;
      ff_lat   <= i_first_fault;
    end
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_valid       = (state_q == ST_RUN);
  assign o_done        = (state_q == ST_DONE);
  assign o_update_bits = o_valid ? lane_bits : '0;
  assign o_beat_idx    = o_valid ? beat_q : '0;
  assign o_last        = o_valid && is_last;
  assign o_fault       = fault_q || (o_valid && beat_fault);
  assign o_alu2_8      = o_busy && (sew_lat == SEW_8);
  assign o_alu2_16     = o_busy && (sew_lat == SEW_16);

endmodule

// File: tb/tb_vector_mask_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_mask_sequencer
// Randomised bench for vector_mask_sequencer (VLEN=256, BEAT_BYTES=4). Each
// command's beat list is computed up front from element-level rules and
// compared against the DUT beat by beat.
// -----------------------------------------------------------------------------
module tb_vector_mask_sequencer;

  localparam int VLEN = 256;
  localparam int BB   = 4;
  localparam int VL_W = 9;
  localparam int BI_W = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [VLEN-1:0] mask;
  logic [VL_W-1:0] vl;
  logic [1:0]      sew;
  logic            mask_skip;
  logic            first_fault;
  logic            busy;
  logic            valid;
  logic            ready;
  logic [BB-1:0]   update_bits;
  logic [BI_W-1:0] beat_idx;
  logic            last;
  logic            fault;
  logic            alu2_8;
  logic            alu2_16;
  logic            done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vector_mask_sequencer #(.VLEN(VLEN), .BEAT_BYTES(BB)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_mask        (mask),
    .i_vl          (vl),
    .i_sew         (sew),
    .i_mask_skip   (mask_skip),
    .i_first_fault (first_fault),
    .o_busy        (busy),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_update_bits (update_bits),
    .o_beat_idx    (beat_idx),
    .o_last        (last),
    .o_fault       (fault),
    .o_alu2_8      (alu2_8),
    .o_alu2_16     (alu2_16),
    .o_done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},  busy,        0);
    chk({tag, ".valid"}, valid,       0);
    chk({tag, ".upd"},   update_bits, 0);
    chk({tag, ".idx"},   beat_idx,    0);
    chk({tag, ".last"},  last,        0);
    chk({tag, ".fault"}, fault,       0);
    chk({tag, ".done"},  done,        0);
    chk({tag, ".alu8"},  alu2_8,      0);
    chk({tag, ".alu16"}, alu2_16,     0);
  endtask

  task automatic scramble_inputs();
    start       = 1'($urandom_range(0, 1));
    mask        = {8{$urandom}};
    vl          = VL_W'($urandom_range(0, 300));
    sew         = 2'($urandom_range(0, 3));
    mask_skip   = 1'($urandom_range(0, 1));
    first_fault = 1'($urandom_range(0, 1));
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles at beat 1
  task automatic run_cmd(input logic [VLEN-1:0] m, input int cvl, input logic [1:0] csew,
                         input bit skip, input bit ff, input int mode);
    int sb, vmax, v, epb, nb, b, guard, stall, fbeat, sew_n, e;
    bit ok, cfault, rdy;
    bit en_arr[VLEN];
    logic [BB-1:0] upd[$];
    logic [BB-1:0] u;

    // Reference: element enables, then group them into beats.
    sew_n = (csew == 2'd3) ? 2 : int'(csew);
    sb    = 1 << sew_n;
    vmax  = VLEN / (8 * sb);
    v     = (cvl < vmax) ? cvl : vmax;
    epb   = BB / sb;
    ok = 1'b1; cfault = 1'b0; fbeat = 0;
    for (int i = 0; i < v; i++) begin
      en_arr[i] = skip || m[i];
      if (ff) begin
        if (!en_arr[i] && ok) begin
          cfault = 1'b1;
          fbeat  = i / epb;
        end
        ok        = ok && en_arr[i];
        en_arr[i] = ok;
      end
    end
    nb = cfault ? fbeat + 1 : (v + epb - 1) / epb;
    for (int bb = 0; bb < nb; bb++) begin
      u = '0;
      for (int k = 0; k < epb; k++) begin
        e = bb * epb + k;
        if (e < v && en_arr[e])
          for (int s = 0; s < sb; s++) u[k * sb + s] = 1'b1;
      end
      upd.push_back(u);
    end

    @(negedge clk);
    chk("idle.busy", busy, 0);
    start       = 1'b1;
    mask        = m;
    vl          = VL_W'(cvl);
    sew         = csew;
    mask_skip   = skip;
    first_fault = ff;
    @(negedge clk);
    scramble_inputs();

    if (nb == 0) begin
      chk("empty.valid", valid, 0);
      chk("empty.done",  done,  1);
      chk("empty.busy",  busy,  1);
    end else begin
      b = 0; guard = 0; stall = 0;
      while (b < nb && guard < 200) begin
        chk("beat.valid", valid,       1);
        chk("beat.idx",   beat_idx,    b);
        chk("beat.upd",   update_bits, upd[b]);
        chk("beat.last",  last,        (b == nb - 1));
        chk("beat.fault", fault,       (cfault && b == nb - 1));
        chk("beat.done",  done,        0);
        chk("beat.alu8",  alu2_8,      (sew_n == 0));
        chk("beat.alu16", alu2_16,     (sew_n == 1));
        rdy = 1'b1;
        if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
        if (mode == 2 && b == 1 && stall < 3) begin
          rdy = 1'b0;
          stall++;
        end
        ready = rdy;
        @(negedge clk);
        if (rdy) b++;
        scramble_inputs();
        guard++;
      end
      chk("beat.budget", (guard < 200), 1);
      chk("fin.done",  done,        1);
      chk("fin.valid", valid,       0);
      chk("fin.upd",   update_bits, 0);
      chk("fin.last",  last,        0);
      chk("fin.fault", fault,       cfault);
    end
    start = 1'b0;
    @(negedge clk);
    chk("post.done",  done,    0);
    chk("post.busy",  busy,    0);
    chk("post.fault", fault,   cfault);
    chk("post.alu8",  alu2_8,  0);
    chk("post.alu16", alu2_16, 0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("hold.fault", fault, cfault);
    end
  endtask

  task automatic reset_mid_run();
    logic [VLEN-1:0] m;
    m = {8{$urandom}};
    @(negedge clk);
    start = 1'b1; mask = m; vl = VL_W'(32); sew = 2'd0;
    mask_skip = 1'b0; first_fault = 1'b0; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.beat2.idx",   beat_idx, 2);
    chk("rst.beat2.valid", valid,    1);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk_all_zero("rst.after");
    @(negedge clk);
    chk("rst.nostart.busy", busy, 0);
  endtask

  logic [VLEN-1:0] rm;

  initial begin
    rst = 1'b1; start = 1'b0; mask = '0; vl = '0; sew = '0;
    mask_skip = 1'b0; first_fault = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    run_cmd(256'hA5, 8, 2'd0, 1'b0, 1'b0, 0);
    run_cmd(256'h5,  3, 2'd1, 1'b0, 1'b0, 0);
    run_cmd(256'hF7, 8, 2'd0, 1'b0, 1'b1, 0);
    run_cmd(256'h0,  4, 2'd2, 1'b1, 1'b0, 2);
    run_cmd({8{$urandom}}, 0, 2'd1, 1'b0, 1'b0, 0);
    run_cmd('1, 300, 2'd3, 1'b0, 1'b0, 1);
    run_cmd('1, 256, 2'd0, 1'b0, 1'b1, 0);
    reset_mid_run();
    run_cmd({8{$urandom}}, 32, 2'd0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 250; n++) begin
      bit ffm;
      ffm = 1'($urandom_range(0, 1));
      if (ffm) begin
        rm = '1;
        if ($urandom_range(0, 2) != 0) rm[$urandom_range(0, VLEN - 1)] = 1'b0;
      end else begin
        rm = {8{$urandom}};
      end
      run_cmd(rm, $urandom_range(0, 300), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0), ffm, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
